// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared types for the memory bus front end: access size codes,
//               bus sequencer states, transfer owner, and the alignment rule
//               used to reject a request before it reaches the bus.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // An access must sit on a multiple of its own size. The unused size code
  // is treated as a word so that it can never produce a partial-lane strobe.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return a[0];
      default:   return (a != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_fmt
// Description : Combinational little-endian lane formatter.
//               Store side: replicates the right-justified store data onto
//               every lane and selects the active byte enables.
//               Load side: picks the addressed byte/half out of the bus word
//               and sign- or zero-extends it to 32 bits.
// Ports       : size       access size (mem_size_t)
//               addr_lo    byte offset within the word
//               sext       1 = sign-extend loads
//               wdata      right-justified store data
//               readdata   raw bus word
//               byteenable active byte lanes
//               writedata  lane-replicated store data
//               rdata      extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
  import bus_arbiter_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = readdata[{addr_lo, 3'b000} +: 8];
  assign w_half = readdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    byteenable = 4'b1111;
    writedata  = wdata;
    rdata      = readdata;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata      = {{24{sext & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        rdata      = {{16{sext & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Sole Avalon-MM master for the multicycle core. Arbitrates the
//               memory bus between instruction fetch and data load/store,
//               sequences each transfer through waitrequest, and stalls the
//               core until the owner's ack pulse.
// Ports       : clk, reset_i            clock, synchronous active-high reset
//               if_req_i/if_addr_i      fetch request (held until if_ack_o)
//               if_ack_o/if_data_o      fetch completion pulse / fetched word
//               d_req_i, d_we_i, d_addr_i, d_size_i, d_signed_i, d_wdata_i
//                                       data request (held until d_ack_o)
//               d_ack_o/d_rdata_o       data completion pulse / load data
//               misalign_o              ack of a rejected misaligned request
//               stall_o                 core stall
//               avm_*                   Avalon-MM master port
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_signed_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        misalign_o,
  output logic        stall_o,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  input  logic        avm_waitrequest_i,
  output logic [31:0] avm_writedata_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic [31:0] avm_readdata_i
);

  bus_state_t  r_state, w_state_nxt;
  owner_t      r_owner;
  logic        r_we;
  mem_size_t   r_size;
  logic        r_sext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_misalign;
  logic [31:0] r_if_data;
  logic [31:0] r_d_rdata;

  logic        w_grant_d;
  logic        w_grant_if;
  mem_size_t   w_req_size;
  logic [31:0] w_req_addr;
  logic        w_req_misalign;
  logic [3:0]  w_fmt_be;
  logic [31:0] w_fmt_wdata;
  logic [31:0] w_fmt_rdata;

  // The loser of a simultaneous request simply keeps its req high and is
  // picked up the next time the sequencer is back in IDLE.
  assign w_grant_d      = d_req_i & (DATA_PRIORITY | ~if_req_i);
  assign w_grant_if     = if_req_i & ~w_grant_d;
  assign w_req_size     = w_grant_d ? mem_size_t'(d_size_i) : SIZE_WORD;
  assign w_req_addr     = w_grant_d ? d_addr_i : if_addr_i;
  assign w_req_misalign = is_misaligned(w_req_size, w_req_addr[1:0]);

  mem_lane_fmt u_lane_fmt (
    .size       (r_size),
    .addr_lo    (r_addr[1:0]),
    .sext       (r_sext),
    .wdata      (r_wdata),
    .readdata   (avm_readdata_i),
    .byteenable (w_fmt_be),
    .writedata  (w_fmt_wdata),
    .rdata      (w_fmt_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_size     <= SIZE_WORD;
      r_sext     <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_misalign <= 1'b0;
      r_if_data  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && (w_grant_d || w_grant_if)) begin
        r_owner    <= w_grant_d ? OWN_D : OWN_IF;
        r_we       <= w_grant_d & d_we_i;
        r_size     <= w_req_size;
        r_sext     <= w_grant_d & d_signed_i;
        r_addr     <= w_req_addr;
        r_wdata    <= w_grant_d ? d_wdata_i : 32'd0;
        r_misalign <= w_req_misalign;
      end
      // Load data is formatted straight off the bus on the completing edge so
      // it is already valid during the RESP (ack) cycle, then held.
      if (r_state == ACCESS && !avm_waitrequest_i && !r_we) begin
        if (r_owner == OWN_IF) begin
          r_if_data <= avm_readdata_i;
        end else begin
          r_d_rdata <= w_fmt_rdata;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d || w_grant_if) begin
          w_state_nxt = w_req_misalign ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!avm_waitrequest_i) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    avm_read_o       = 1'b0;
    avm_write_o      = 1'b0;
    avm_address_o    = 32'd0;
    avm_byteenable_o = 4'd0;
    avm_writedata_o  = 32'd0;
    if_ack_o         = 1'b0;
    d_ack_o          = 1'b0;
    misalign_o       = 1'b0;
    if (r_state == ACCESS) begin
      avm_read_o       = ~r_we;
      avm_write_o      = r_we;
      avm_address_o    = {r_addr[31:2], 2'b00};
      avm_byteenable_o = w_fmt_be;
      avm_writedata_o  = w_fmt_wdata;
    end
    if (r_state == RESP) begin
      if_ack_o   = (r_owner == OWN_IF);
      d_ack_o    = (r_owner == OWN_D);
      misalign_o = r_misalign;
    end
  end

  assign if_data_o = r_if_data;
  assign d_rdata_o = r_d_rdata;
  assign stall_o   = (if_req_i | d_req_i) & ~(if_ack_o | d_ack_o);

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sole Avalon-MM master front end for the multicycle core.
- Shares the single memory bus between instruction fetch and data load/store requesters.
- Sequences each transfer through waitrequest stalls and drives a stall back to the core FSM.
- Handles byte-lane alignment, byteenable generation and load sign/zero extension for byte, half and word accesses.

Parameters:
DATA_PRIORITY, 1, 1: data port wins simultaneous requests; 0: fetch wins.

Ports:
clk  in  1  system clock
reset_i  in  1  synchronous active-high reset
if_req_i  in  1  fetch request, held until if_ack_o
if_addr_i  in  32  fetch byte address (PC)
if_ack_o  out  1  one-cycle fetch completion pulse
if_data_o  out  32  fetched word, valid with if_ack_o, held until next fetch ack
d_req_i  in  1  data request, held until d_ack_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  32  data byte address
d_size_i  in  2  mem_size_t: BYTE / HALF / WORD
d_signed_i  in  1  load sign-extends when 1
d_wdata_i  in  32  store data, right-justified
d_ack_o  out  1  one-cycle data completion pulse
d_rdata_o  out  32  extended load data, valid with d_ack_o, held until next data ack
misalign_o  out  1  with ack: request rejected as misaligned, no bus cycle issued
stall_o  out  1  (if_req_i | d_req_i) & ~(if_ack_o | d_ack_o)
avm_address_o  out  32  word-aligned bus address
avm_read_o  out  1  Avalon read
avm_write_o  out  1  Avalon write
avm_waitrequest_i  in  1  Avalon waitrequest
avm_writedata_o  out  32  lane-replicated store data
avm_byteenable_o  out  4  active byte lanes
avm_readdata_i  in  32  Avalon read data

Behaviour:
Clocking and reset:
- One clock domain, clk.
- Reset is synchronous and active-high on reset_i.
- Reset values: state IDLE; all avm_* outputs, acks and misalign_o at 0; if_data_o and d_rdata_o at 0.

State machine (bus_state_t):
- IDLE:
  - No request: stay in IDLE.
  - Data request wins (d_req_i alone, or both with DATA_PRIORITY=1): latch owner, we, size, signed, addr and wdata.
  - Fetch request wins (if_req_i alone, or both with DATA_PRIORITY=0): latch owner and addr with size forced to WORD, we=0.
  - Aligned request: go to ACCESS. Misaligned request: go to RESP with misalign flag set.
  - Loser of a simultaneous request keeps its req high and is served after the winner completes.
- ACCESS:
  - avm_read_o = ~we, avm_write_o = we, driven from latched values.
  - All avm outputs stay stable while avm_waitrequest_i = 1.
  - avm_waitrequest_i = 0 at the clock edge: go to RESP, capture avm_readdata_i when reading.
- RESP:
  - Owner's ack is high for exactly this cycle; misalign_o = latched flag.
  - Read data is formatted from the captured word.
  - Always go to IDLE next cycle.

Latency and handshake:
- Minimum is 3 cycles from req to return to IDLE: req in cycle 0, bus strobe in cycle 1, ack in cycle 2.
- Each waitrequest cycle adds one cycle.
- Requester drops req in the cycle after ack. A req still high in IDLE is a new transfer.

Alignment and lanes (little-endian; a = latched addr[1:0]):
- avm_address_o = {addr[31:2], 2'b00}.
- WORD:
  - Misaligned if a != 0.
  - byteenable 4'b1111; wdata passed through.
- HALF:
  - Misaligned if a[0] = 1.
  - byteenable a[1] ? 1100 : 0011.
  - Store drives {2{wdata[15:0]}}.
  - Load takes readdata[16*a[1] +: 16], extended to 32 bits.
- BYTE:
  - byteenable 4'b0001 << a.
  - Store drives {4{wdata[7:0]}}.
  - Load takes readdata[8*a +: 8], extended to 32 bits.
- Fetch: misaligned if if_addr_i[1:0] != 0.
- Misaligned requests: no avm strobe at all; ack and misalign_o pulse together; the data output is not updated.

Reset and corner cases:
- Reset mid-ACCESS: strobes drop at the next edge even if waitrequest is high. This protocol break is accepted because reset restarts the system.
- Req dropped before ack: protocol violation by the requester; the transfer still completes and acks.

Decomposition:
- Package codes gains:
  - mem_size_t (SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2).
  - bus_state_t (IDLE, ACCESS, RESP).
  - owner_t (OWN_IF, OWN_D).
- Sub-module mem_lane_fmt (combinational):
  - Store side: size, addr[1:0], wdata -> byteenable, writedata.
  - Load side: size, addr[1:0], signed, readdata -> extended load data.
  - Unit-tested separately.

Test Plan:
1. Fetch at 0xBFC00000, waitrequest 0, readdata 0x3C021234 -> avm_read_o high one cycle, address 0xBFC00000, if_ack_o in cycle 2, if_data_o = 0x3C021234.
2. Load word at 0x1000 with waitrequest high for 3 cycles -> address, read and byteenable stable for 4 cycles, d_ack_o in cycle 5, stall_o high cycles 0-4.
3. Simultaneous if_req (0x400) and d_req (0x2000) with DATA_PRIORITY=1 -> data transfer first, then fetch; the two acks are never in the same cycle.
4. Signed byte load at 0x1003 with readdata 0x80FFFFFF -> byteenable 1000, d_rdata_o = 0xFFFFFF80. Same access unsigned -> 0x00000080.
5. Half store 0xABCD1234 at 0x1002 -> avm_write_o, byteenable 1100, writedata 0x12341234. Half load at 0x1001 -> no strobe, d_ack_o and misalign_o pulse in cycle 1.
6. reset_i asserted during ACCESS with waitrequest high -> next edge: avm_read_o 0, state IDLE, no ack.
